// File: rtl/dmem_arbiter.sv
// Shared data memory with a two-port round-robin arbiter (core and host loader).
// One access per clock; read data returns one cycle after grant on the granted port.
module dmem_arbiter #(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [15:0]   conflict_cnt,
    output logic [0:0]    arb_state
);

    localparam logic [0:0] PREF_CPU  = 1'b0;
    localparam logic [0:0] PREF_HOST = 1'b1;
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);

    logic [0:0]    state;
    logic [DW-1:0] mem [DEPTH];

    logic          acc_en;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          in_range;
    logic [DW-1:0] rd_word;

    assign arb_state = state;

    // Handshake: a port raises req with its command fields and must hold both
    // until gnt is seen high; the access happens at the rising edge ending that
    // gnt cycle. Reads answer with a one-cycle rvalid pulse in the next cycle.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!sys_rst) begin
            if (cpu_req && (!host_req || state == PREF_CPU))
                cpu_gnt = 1'b1;
            else if (host_req)
                host_gnt = 1'b1;
        end
    end

    always_comb begin
        acc_en    = cpu_gnt | host_gnt;
        acc_we    = cpu_gnt ? cpu_we    : host_we;
        acc_addr  = cpu_gnt ? cpu_addr  : host_addr;
        acc_wdata = cpu_gnt ? cpu_wdata : host_wdata;
        in_range  = {1'b0, acc_addr} < DEPTH_L;
        rd_word   = in_range ? mem[acc_addr] : '0;
    end

    // Memory contents deliberately survive reset so the host preload is kept.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we && in_range)
            mem[acc_addr] <= acc_wdata;
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= PREF_CPU;
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (cpu_gnt)
                state <= PREF_HOST;
            else if (host_gnt)
                state <= PREF_CPU;

            cpu_rvalid  <= cpu_gnt && !cpu_we;
            host_rvalid <= host_gnt && !host_we;
            if (cpu_gnt && !cpu_we)
                cpu_rdata <= rd_word;
            if (host_gnt && !host_we)
                host_rdata <= rd_word;

            if (cpu_req && host_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration, memory and counter rules.
module tb_dmem_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic [15:0]   conflict_cnt;
    logic [0:0]    arb_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .conflict_cnt(conflict_cnt), .arb_state(arb_state)
    );

    // Reference model: whose turn it is, word array, pending read results, conflict tally.
    logic          m_pref_cpu;
    logic [DW-1:0] m_mem [16];
    logic          m_cv, m_hv;
    logic [DW-1:0] m_cd, m_hd;
    int            m_cnt;
    logic          m_cg, m_hg;

    assign m_cg = cpu_req && (!host_req || m_pref_cpu);
    assign m_hg = host_req && !m_cg;

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_pref_cpu <= 1'b1;
            m_cv <= 1'b0; m_hv <= 1'b0;
            m_cd <= '0;   m_hd <= '0;
            m_cnt <= 0;
        end else begin
            if (m_cg) begin
                if (cpu_we && cpu_addr < DEPTH) m_mem[cpu_addr] <= cpu_wdata;
                if (!cpu_we) m_cd <= (cpu_addr < DEPTH) ? m_mem[cpu_addr] : '0;
                m_pref_cpu <= 1'b0;
            end else if (m_hg) begin
                if (host_we && host_addr < DEPTH) m_mem[host_addr] <= host_wdata;
                if (!host_we) m_hd <= (host_addr < DEPTH) ? m_mem[host_addr] : '0;
                m_pref_cpu <= 1'b1;
            end
            m_cv <= m_cg && !cpu_we;
            m_hv <= m_hg && !host_we;
            if (cpu_req && host_req) m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic hr, input logic hw,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        cpu_req = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle();
        sys_rst = 1'b1;
        #2 sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        drive(1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin errors++;
            $display("FAIL reset_gnt got=%b%b exp=00", cpu_gnt, host_gnt); end
        @(negedge clk);
        idle();
        sys_rst = 1'b0;
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin errors++;
            $display("FAIL reset_rvalid got=%b%b exp=00", cpu_rvalid, host_rvalid); end
        checks++; if (cpu_rdata !== 16'h0 || host_rdata !== 16'h0) begin errors++;
            $display("FAIL reset_rdata got=%h/%h exp=0000/0000", cpu_rdata, host_rdata); end
        checks++; if (conflict_cnt !== 16'h0) begin errors++;
            $display("FAIL reset_cnt got=%h exp=0000", conflict_cnt); end
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, '0, '0);
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL persist_write_gnt got=%b exp=1", cpu_gnt); end
        pulse_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd3, '0);
        @(negedge clk);
        idle();
        #1;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'hBEEF) begin errors++;
            $display("FAIL persist_read got=%b/%h exp=1/beef", host_rvalid, host_rdata); end
    endtask

    task automatic test_single_port();
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd5, 16'h1234);
        #1;
        checks++; if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++;
            $display("FAIL single_write_gnt got=%b%b exp=01", cpu_gnt, host_gnt); end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, '0);
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++;
            $display("FAIL single_read_gnt got=%b exp=1", host_gnt); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'h1234 || cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL single_read_data got=%b/%h cpu_rvalid=%b exp=1/1234 cpu_rvalid=0",
                     host_rvalid, host_rdata, cpu_rvalid); end
        @(negedge clk);
        #1;
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 16'h1234) begin errors++;
            $display("FAIL single_pulse_hold got=%b/%h exp=0/1234", host_rvalid, host_rdata); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd3, '0);
            #1;
            checks++; if (cpu_gnt !== (i % 2 == 0) || host_gnt !== (i % 2 == 1)) begin errors++;
                $display("FAIL rr_gnt[%0d] got=%b%b exp=%b%b", i, cpu_gnt, host_gnt,
                         (i % 2 == 0), (i % 2 == 1)); end
            if (i > 0) begin
                checks++; if (cpu_rvalid !== ((i - 1) % 2 == 0)) begin errors++;
                    $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, cpu_rvalid, ((i - 1) % 2 == 0)); end
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (conflict_cnt !== 16'd4) begin errors++;
            $display("FAIL rr_cnt got=%0d exp=4", conflict_cnt); end
        checks++; if (cpu_rdata !== 16'h1234 || host_rdata !== 16'hBEEF) begin errors++;
            $display("FAIL rr_rdata got=%h/%h exp=1234/beef", cpu_rdata, host_rdata); end
    endtask

    task automatic test_read_after_write();
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd7, 16'h00AA, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd7, '0);
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++;
            $display("FAIL raw_gnt got=%b exp=1", host_gnt); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'h00AA) begin errors++;
            $display("FAIL raw_data got=%b/%h exp=1/00aa", host_rvalid, host_rdata); end
        // Last grant went to host, so under conflict the cpu write goes first.
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd7, 16'h55AA, 1'b1, 1'b0, 4'd7, '0);
        #1;
        checks++; if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin errors++;
            $display("FAIL raw_conflict_gnt got=%b%b exp=10", cpu_gnt, host_gnt); end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd7, '0);
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++;
            $display("FAIL raw_wait_gnt got=%b exp=1", host_gnt); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (host_rdata !== 16'h55AA) begin errors++;
            $display("FAIL raw_conflict_data got=%h exp=55aa", host_rdata); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd14, 16'h5555, 1'b0, 1'b0, '0, '0);
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL oor_write_gnt got=%b exp=1", cpu_gnt); end
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd14, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL oor_read_gnt got=%b exp=1", cpu_gnt); end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd15, '0);
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0) begin errors++;
            $display("FAIL oor_cpu_read got=%b/%h exp=1/0000", cpu_rvalid, cpu_rdata); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'h0) begin errors++;
            $display("FAIL oor_host_read got=%b/%h exp=1/0000", host_rvalid, host_rdata); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd14, '0, 1'b1, 1'b0, 4'd13, '0);
        repeat (65534) @(negedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'd65534) begin errors++;
            $display("FAIL sat_before got=%0d exp=65534", conflict_cnt); end
        @(negedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'hFFFF) begin errors++;
            $display("FAIL sat_reach got=%h exp=ffff", conflict_cnt); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'hFFFF) begin errors++;
            $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_mid_read_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd9, 16'hABCD, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd9, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hABCD || cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL mid_pre got=%b/%h gnt=%b exp=1/abcd gnt=1", cpu_rvalid, cpu_rdata, cpu_gnt); end
        #2 sys_rst = 1'b1;
        #1;
        checks++; if (cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0) begin errors++;
            $display("FAIL mid_async got=%b/%b/%h exp=0/0/0000", cpu_gnt, cpu_rvalid, cpu_rdata); end
        @(negedge clk);
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0 || conflict_cnt !== 16'h0) begin errors++;
            $display("FAIL mid_lost got=%b/%h cnt=%h exp=0/0000 cnt=0000", cpu_rvalid, cpu_rdata, conflict_cnt); end
        sys_rst = 1'b0;
        drive(1'b1, 1'b0, 4'd9, '0, 1'b1, 1'b0, 4'd9, '0);
        #1;
        checks++; if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin errors++;
            $display("FAIL mid_pref_cpu got=%b%b exp=10", cpu_gnt, host_gnt); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        int c_wait = 0;
        int h_wait = 0;
        logic c_done = 1'b1;
        logic h_done = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(a), DW'($urandom));
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (c_done) begin
                cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
            end
            if (h_done) begin
                host_req = ($urandom_range(0, 3) != 0); host_we = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom_range(0, 15)); host_wdata = DW'($urandom);
            end
            #1;
            checks++; if (cpu_gnt !== m_cg || host_gnt !== m_hg) begin errors++;
                $display("FAIL rnd_gnt[%0d] got=%b%b exp=%b%b", n, cpu_gnt, host_gnt, m_cg, m_hg); end
            checks++; if (cpu_rvalid !== m_cv || cpu_rdata !== m_cd) begin errors++;
                $display("FAIL rnd_cpu_rd[%0d] got=%b/%h exp=%b/%h", n, cpu_rvalid, cpu_rdata, m_cv, m_cd); end
            checks++; if (host_rvalid !== m_hv || host_rdata !== m_hd) begin errors++;
                $display("FAIL rnd_host_rd[%0d] got=%b/%h exp=%b/%h", n, host_rvalid, host_rdata, m_hv, m_hd); end
            checks++; if (conflict_cnt !== 16'(m_cnt)) begin errors++;
                $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, conflict_cnt, m_cnt); end
            c_wait = (cpu_req && !cpu_gnt) ? c_wait + 1 : 0;
            h_wait = (host_req && !host_gnt) ? h_wait + 1 : 0;
            checks++; if (c_wait > 1 || h_wait > 1) begin errors++;
                $display("FAIL rnd_starve[%0d] got=%0d/%0d exp<=1", n, c_wait, h_wait); end
            c_done = !cpu_req || cpu_gnt;
            h_done = !host_req || host_gnt;
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_port();
        test_round_robin();
        test_read_after_write();
        test_out_of_range();
        test_saturation();
        test_mid_read_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
